pc_ras_unit: RTL

- Parametrised program counter with an integrated return-address stack (RAS).
- Extends the LC-3 PC with:
  - configurable width and reset vector;
  - a vector-load source;
  - a "hold" mux code;
  - hardware push/pop of return addresses for JSR/JSRR/RET, with a bus fallback when the stack is empty.
- Sits in the datapath in place of the PC register. o_PC drives the bus gate and ADDR1MUX.

---
 rtl/pc_ras_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pc_ras_unit.sv
// Program counter with an integrated circular return-address stack.
// Optional macro PC_PREV_EN adds o_PC_Prev, the PC value before the last effective load.
module pc_ras_unit #(
  parameter int               WIDTH        = 16,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 'h3000,
  parameter int               INC          = 1
) (
  input  logic                             i_CLK,
  input  logic                             i_RST,
  input  logic                             i_LD_PC,
  input  logic [2:0]                       i_PCMUX,
  input  logic                             i_RAS_Push,
  input  logic                             i_RAS_Clr,
  input  logic [WIDTH-1:0]                 i_Bus,
  input  logic [WIDTH-1:0]                 i_Addr,
  input  logic [WIDTH-1:0]                 i_Vector,
  output logic [WIDTH-1:0]                 o_PC,
  output logic [WIDTH-1:0]                 o_RAS_Top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   o_RAS_Count,
  output logic                             o_RAS_Empty,
  output logic                             o_RAS_Full,
  output logic                             o_RAS_Ovf,
  output logic                             o_RAS_Unf
`ifdef PC_PREV_EN
  ,
  output logic [WIDTH-1:0]                 o_PC_Prev
`endif
);

  localparam int               CW       = $clog2(RAS_DEPTH + 1);
  localparam int               PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(RAS_DEPTH);
  localparam logic [PW-1:0]    LAST_IDX = PW'(RAS_DEPTH - 1);
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);

  typedef enum logic [2:0] {
    SRC_INC  = 3'b000,
    SRC_BUS  = 3'b001,
    SRC_ADDR = 3'b010,
    SRC_POP  = 3'b011,
    SRC_VEC  = 3'b100
  } pcmux_e;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]    r_top_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] top_val;
  logic [PW-1:0]    ptr_up;
  logic [PW-1:0]    ptr_down;
  logic [PW-1:0]    wr_ptr;
  logic             empty;
  logic             full;
  logic             load_en;
  logic             pop_req;
  logic             push_req;
  logic             stack_we;

  assign pc_inc   = r_pc + INC_W;
  assign empty    = (r_count == '0);
  assign full     = (r_count == DEPTH_C);
  assign top_val  = r_stack[r_top_ptr];
  assign ptr_up   = (r_top_ptr == LAST_IDX) ? '0 : r_top_ptr + PW'(1);
  assign ptr_down = (r_top_ptr == '0) ? LAST_IDX : r_top_ptr - PW'(1);

  // Codes above SRC_VEC are hold codes: no PC change, but push still applies.
  assign load_en  = i_LD_PC && (i_PCMUX <= SRC_VEC);
  assign pop_req  = i_LD_PC && (i_PCMUX == SRC_POP);
  assign push_req = i_LD_PC && i_RAS_Push;
  assign stack_we = push_req && !i_RAS_Clr && !i_RST;

  // A push paired with a real pop reuses the popped slot; otherwise advance.
  assign wr_ptr = (pop_req && !empty) ? r_top_ptr : ptr_up;

  always_comb begin
    pc_next = r_pc;
    case (i_PCMUX)
      SRC_INC:  pc_next = pc_inc;
      SRC_BUS:  pc_next = i_Bus;
      SRC_ADDR: pc_next = i_Addr;
      SRC_POP:  pc_next = empty ? i_Bus : top_val;
      SRC_VEC:  pc_next = i_Vector;
      default:  pc_next = r_pc;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_pc      <= RESET_VECTOR;
      r_top_ptr <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      if (load_en)
        r_pc <= pc_next;
      if (i_RAS_Clr) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_unf   <= 1'b0;
      end else if (push_req && pop_req) begin
        if (empty) begin
          r_top_ptr <= ptr_up;
          r_count   <= CW'(1);
          r_unf     <= 1'b1;
        end
      end else if (push_req) begin
        r_top_ptr <= ptr_up;
        if (full)
          r_ovf <= 1'b1;
        else
          r_count <= r_count + CW'(1);
      end else if (pop_req) begin
        if (empty) begin
          r_unf <= 1'b1;
        end else begin
          r_top_ptr <= ptr_down;
          r_count   <= r_count - CW'(1);
        end
      end
    end
  end

  // Stack storage has no reset; only entries covered by r_count are meaningful.
  always_ff @(posedge i_CLK) begin
    if (stack_we)
      r_stack[wr_ptr] <= pc_inc;
  end

`ifdef PC_PREV_EN
  logic [WIDTH-1:0] r_pc_prev;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)
      r_pc_prev <= RESET_VECTOR;
    else if (load_en)
      r_pc_prev <= r_pc;
  end

  assign o_PC_Prev = r_pc_prev;
`endif

  assign o_PC        = r_pc;
  assign o_RAS_Top   = empty ? '0 : top_val;
  assign o_RAS_Count = r_count;
  assign o_RAS_Empty = empty;
  assign o_RAS_Full  = full;
  assign o_RAS_Ovf   = r_ovf;
  assign o_RAS_Unf   = r_unf;

endmodule
